adder_8_bit: RTL and testbench
==============================

# adder_8_bit

Eight-bit two-operand adder. It provides an always-present combinational unsigned sum of `a` and `b`, plus a one-stage registered arithmetic path with add/subtract, carry-in, carry-out, signed-overflow, zero flag and optional signed saturation. It is a leaf datapath block used wherever the design needs a small ALU-style add with both a zero-latency result and a pipelined, flag-bearing result.

## Interface
- One clock; reset is asynchronous and active-low. The ports are `clk` and `rst_n`.
- Parameter `SATURATE`, default 0: when 1, the registered result clamps on signed overflow.
- `clk`  in  1  clock; all registers update on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `a`  in  8  operand A.
- `b`  in  8  operand B.
- `sum`  out  8  combinational `(a + b) mod 256`, unsigned.
- `in_valid`  in  1  qualifies `a`, `b`, `sub` and `cin` for the registered path.
- `sub`  in  1  registered-path operation select: 0 = `a + b + cin`, 1 = `a - b`.
- `cin`  in  1  carry-in for add; ignored when `sub=1`.
- `sum_q`  out  8  registered result.
- `cout_q`  out  1  registered carry-out. For subtract, 1 means no borrow.
- `ovf_q`  out  1  registered two's-complement overflow.
- `zero_q`  out  1  registered flag, 1 when `sum_q == 0`.
- `out_valid`  out  1  registered `in_valid`.

## Operation
- The `sum` output is purely combinational.
  - It depends only on `a` and `b`; `clk`, `rst_n`, `sub`, `cin` and `in_valid` have no effect on it.
  - `sum` must be valid whenever `a`/`b` are stable, including while reset is asserted or the clock is absent.
  - The carry out of this path is discarded (wrap-around).
- The registered path computes a 9-bit value `r`:
  - `r = a + b + cin` when `sub=0`.
  - `r = a + (~b) + 1` when `sub=1`.
  - `cout = r[8]`.
- Signed overflow `ovf` is 1 when:
  - add: `a[7]==b[7]` and `r[7]!=a[7]`;
  - subtract: `a[7]!=b[7]` and `r[7]!=a[7]`.
- Result value:
  - `SATURATE=0`: result is `r[7:0]`.
  - `SATURATE=1` and `ovf=1`: result is 0x7F if `a[7]==0`, else 0x80.
  - `cout_q` and `ovf_q` always report the raw, unsaturated flags.
- `zero_q` is computed from the final, possibly saturated, result.
- Must be built as an explicit 8-stage ripple of full-adder cells. The combinational `sum` path and the registered path may share the cell chain only if `sum` stays independent of `sub`/`cin`.
- Undriven `sub`/`cin` must never affect `sum`.

## Timing
- Reset: when `rst_n` goes low, asynchronously and immediately, `sum_q=0`, `cout_q=0`, `ovf_q=0`, `zero_q=0`, `out_valid=0`. Outputs hold these values until the first rising edge after `rst_n` goes high.
- Latency: a rising edge with `in_valid=1` captures the result; `sum_q`/flags/`out_valid=1` are visible after that edge (1 cycle).
- A rising edge with `in_valid=0`:
  - `sum_q`, `cout_q`, `ovf_q`, `zero_q` hold their previous values;
  - `out_valid` becomes 0.
- Back-to-back `in_valid` every cycle gives one result per cycle with no bubbles.
- Reset mid-stream discards the in-flight result. The first valid output after release comes one cycle after the first accepted input.
- There is no backpressure; downstream must accept every `out_valid` pulse.
- Combinational `sum` settles within 1 ns in simulation (zero-delay model).

## Test plan
- `a=35`, `b=62`, no clock, `rst_n` low -> `sum=97` within 1 ns; then `a=19`, `b=14` -> `sum=33`.
- Wrap-around: `a=200`, `b=100`, `sub=0`, `cin=0`, `in_valid=1`, one edge -> `sum=44`, `sum_q=44`, `cout_q=1`, `ovf_q=0`, `out_valid=1`.
- Signed overflow: `a=100`, `b=50`, `sub=0`:
  - `SATURATE=0` -> `sum_q=0x96`, `ovf_q=1`, `cout_q=0`;
  - `SATURATE=1` -> `sum_q=0x7F`, `ovf_q=1`.
- Subtract: `a=5`, `b=5`, `sub=1` -> `sum_q=0`, `zero_q=1`, `cout_q=1`, `ovf_q=0`. Then `a=3`, `b=5` -> `sum_q=0xFE`, `cout_q=0`.
- Carry-in and hold: `a=255`, `b=0`, `cin=1` -> `sum_q=0`, `cout_q=1`, `zero_q=1`. Then `in_valid=0` for 3 edges -> outputs hold, `out_valid=0`.
- Reset mid-stream: `in_valid=1` each cycle, assert `rst_n=0` between edges -> all registered outputs 0 immediately, without a clock edge. Release -> first `out_valid` one edge after the next accepted input. `sum` stays correct throughout.

Source files
------------

// File: rtl/adder_8_bit.sv
// rtl/adder_8_bit.sv - 8-bit ripple adder: combinational sum plus registered add/sub with flags

// One full-adder cell of the ripple chain.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));

endmodule

module adder_8_bit #(
   parameter int SATURATE = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] a,
   input  logic [7:0] b,
   output logic [7:0] sum,
   input  logic       in_valid,
   input  logic       sub,
   input  logic       cin,
   output logic [7:0] sum_q,
   output logic       cout_q,
   output logic       ovf_q,
   output logic       zero_q,
   output logic       out_valid
);

   localparam logic SAT_EN = (SATURATE != 0);

   // The unsigned sum path uses its own chain with a hard-wired zero
   // carry-in, so sub/cin (even if undriven) can never reach it.
   logic [8:0] c_u;
   logic [7:0] s_u;

   // Registered path chain: subtract is a + ~b + 1.
   logic [8:0] c_r;
   logic [7:0] b_r;
   logic [7:0] r_lo;

   assign c_u[0] = 1'b0;
   assign b_r    = sub ? ~b : b;
   assign c_r[0] = sub ? 1'b1 : cin;

   for (genvar i = 0; i < 8; i++) begin : g_ripple
      full_adder u_fa_sum (
         .a  (a[i]),
         .b  (b[i]),
         .ci (c_u[i]),
         .s  (s_u[i]),
         .co (c_u[i+1])
      );
      full_adder u_fa_reg (
         .a  (a[i]),
         .b  (b_r[i]),
         .ci (c_r[i]),
         .s  (r_lo[i]),
         .co (c_r[i+1])
      );
   end

   // Final carry of the unsigned chain is discarded: wrap-around sum.
   assign sum = s_u;

   logic       cout_d;
   logic       ovf_d;
   logic [7:0] res_d;

   // Raw flags from the unsaturated result, then optional signed clamp.
   always_comb begin
      cout_d = c_r[8];
      if (sub) begin
         ovf_d = (a[7] != b[7]) && (r_lo[7] != a[7]);
      end else begin
         ovf_d = (a[7] == b[7]) && (r_lo[7] != a[7]);
      end
      res_d = r_lo;
      if (SAT_EN && ovf_d) begin
         res_d = a[7] ? 8'h80 : 8'h7F;
      end
   end

   // Capture on valid; flags hold otherwise; out_valid follows in_valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q     <= 8'h00;
         cout_q    <= 1'b0;
         ovf_q     <= 1'b0;
         zero_q    <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            sum_q  <= res_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
            zero_q <= (res_d == 8'h00);
         end
      end
   end

endmodule

// File: tb/tb_adder_8_bit.sv
// tb/tb_adder_8_bit.sv - directed self-checking bench for adder_8_bit (wrap and saturating builds)

module tb_adder_8_bit;

   logic       clk;
   logic       clk_en;
   logic       rst_n;
   logic [7:0] a;
   logic [7:0] b;
   logic       in_valid;
   logic       sub;
   logic       cin;

   logic [7:0] sum0, sum_q0, sum1, sum_q1;
   logic       cout_q0, ovf_q0, zero_q0, out_valid0;
   logic       cout_q1, ovf_q1, zero_q1, out_valid1;

   int n_checks;
   int n_fails;

   adder_8_bit #(.SATURATE(0)) u_dut_wrap (
      .clk       (clk),
      .rst_n     (rst_n),
      .a         (a),
      .b         (b),
      .sum       (sum0),
      .in_valid  (in_valid),
      .sub       (sub),
      .cin       (cin),
      .sum_q     (sum_q0),
      .cout_q    (cout_q0),
      .ovf_q     (ovf_q0),
      .zero_q    (zero_q0),
      .out_valid (out_valid0)
   );

   adder_8_bit #(.SATURATE(1)) u_dut_sat (
      .clk       (clk),
      .rst_n     (rst_n),
      .a         (a),
      .b         (b),
      .sum       (sum1),
      .in_valid  (in_valid),
      .sub       (sub),
      .cin       (cin),
      .sum_q     (sum_q1),
      .cout_q    (cout_q1),
      .ovf_q     (ovf_q1),
      .zero_q    (zero_q1),
      .out_valid (out_valid1)
   );

   // Clock only runs once enabled so the no-clock sum check is genuine.
   always begin
      #5;
      if (clk_en) clk = ~clk;
   end

   task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%02h expected 0x%02h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_regs0(input string tag, input logic [7:0] s, input logic c,
                              input logic o, input logic z, input logic v);
      check_eq({tag, ".sum_q"},     sum_q0,     s);
      check_eq({tag, ".cout_q"},    {7'd0, cout_q0},    {7'd0, c});
      check_eq({tag, ".ovf_q"},     {7'd0, ovf_q0},     {7'd0, o});
      check_eq({tag, ".zero_q"},    {7'd0, zero_q0},    {7'd0, z});
      check_eq({tag, ".out_valid"}, {7'd0, out_valid0}, {7'd0, v});
   endtask

   task automatic drive(input logic [7:0] va, input logic [7:0] vb, input logic vsub,
                        input logic vcin, input logic vvalid);
      a = va; b = vb; sub = vsub; cin = vcin; in_valid = vvalid;
   endtask

   initial begin
      n_checks = 0;
      n_fails  = 0;
      clk      = 1'b0;
      clk_en   = 1'b0;
      rst_n    = 1'b0;
      drive(8'd35, 8'd62, 1'b0, 1'b0, 1'b0);

      // Combinational sum with reset asserted and no clock.
      #1;
      check_eq("nclk_sum_97", sum0, 8'd97);
      check_eq("nclk_sum_97_sat", sum1, 8'd97);
      check_regs0("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      a = 8'd19; b = 8'd14;
      #1;
      check_eq("nclk_sum_33", sum0, 8'd33);

      rst_n  = 1'b1;
      clk_en = 1'b1;

      // Wrap-around.
      drive(8'd200, 8'd100, 1'b0, 1'b0, 1'b1);
      step();
      check_eq("wrap.sum", sum0, 8'd44);
      check_regs0("wrap", 8'd44, 1'b1, 1'b0, 1'b0, 1'b1);

      // Signed overflow, both builds.
      drive(8'd100, 8'd50, 1'b0, 1'b0, 1'b1);
      step();
      check_regs0("ovf", 8'h96, 1'b0, 1'b1, 1'b0, 1'b1);
      check_eq("ovf_sat.sum_q", sum_q1, 8'h7F);
      check_eq("ovf_sat.ovf_q", {7'd0, ovf_q1}, 8'd1);
      check_eq("ovf_sat.cout_q", {7'd0, cout_q1}, 8'd0);
      check_eq("ovf_sat.zero_q", {7'd0, zero_q1}, 8'd0);

      // Negative overflow clamps to 0x80: -128 + -1.
      drive(8'h80, 8'hFF, 1'b0, 1'b0, 1'b1);
      step();
      check_regs0("novf", 8'h7F, 1'b1, 1'b1, 1'b0, 1'b1);
      check_eq("novf_sat.sum_q", sum_q1, 8'h80);

      // Subtract to zero, then with borrow; cin must be ignored.
      drive(8'd5, 8'd5, 1'b1, 1'b1, 1'b1);
      step();
      check_regs0("sub_eq", 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
      drive(8'd3, 8'd5, 1'b1, 1'b0, 1'b1);
      step();
      check_regs0("sub_lt", 8'hFE, 1'b0, 1'b0, 1'b0, 1'b1);
      check_eq("sub_lt.sum_comb", sum0, 8'd8);

      // Subtract overflow: 0x80 - 1 = 0x7F.
      drive(8'h80, 8'h01, 1'b1, 1'b0, 1'b1);
      step();
      check_regs0("sub_ovf", 8'h7F, 1'b1, 1'b1, 1'b0, 1'b1);
      check_eq("sub_ovf_sat.sum_q", sum_q1, 8'h80);

      // Carry-in, then hold for 3 idle edges.
      drive(8'd255, 8'd0, 1'b0, 1'b1, 1'b1);
      step();
      check_regs0("cin", 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
      drive(8'd7, 8'd9, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step();
         check_regs0($sformatf("hold%0d", i), 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
      end

      // Reset mid-stream.
      drive(8'd10, 8'd20, 1'b0, 1'b0, 1'b1);
      step();
      check_regs0("stream0", 8'd30, 1'b0, 1'b0, 1'b0, 1'b1);
      drive(8'd11, 8'd22, 1'b0, 1'b0, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check_regs0("async_rst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      check_eq("async_rst_sat.sum_q", sum_q1, 8'h00);
      check_eq("async_rst.sum", sum0, 8'd33);
      step();
      check_regs0("rst_edge", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      in_valid = 1'b0;
      #2;
      rst_n = 1'b1;
      step();
      check_regs0("post_rel_idle", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(8'd40, 8'd2, 1'b0, 1'b0, 1'b1);
      step();
      check_regs0("post_rel_first", 8'd42, 1'b0, 1'b0, 1'b0, 1'b1);
      check_eq("post_rel.sum", sum0, 8'd42);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

   // Absolute time limit so the run always ends.
   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
